// File: rtl/serdesphy_ana_pll_pfd.sv
// serdesphy_ana_pll_pfd: behavioural PLL phase-frequency detector with phase-error, slip and lock reporting
//   clk        system clock
//   rst        asynchronous active-high reset
//   enable     detector enable (synchronous)
//   ref_edge   one-cycle strobe, reference clock edge
//   fb_edge    one-cycle strobe, divided feedback clock edge
//   up_pulse   UP to charge pump (reference leads)
//   down_pulse DOWN to charge pump (feedback leads)
//   phase_err  magnitude of last comparison in clk cycles
//   err_sign   0 = ref led, 1 = fb led
//   err_valid  one-cycle strobe, new phase_err/err_sign
//   slip       one-cycle strobe, second leading edge before lagging edge
//   locked     lock indicator
module serdesphy_ana_pll_pfd #(
    parameter int RST_DLY  = 1,
    parameter int ERR_W    = 8,
    parameter int LOCK_TOL = 2,
    parameter int LOCK_CNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ref_edge,
    input  logic             fb_edge,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic [ERR_W-1:0] phase_err,
    output logic             err_sign,
    output logic             err_valid,
    output logic             slip,
    output logic             locked
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int RW = (RST_DLY > 1) ? $clog2(RST_DLY) : 1;
    localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};
    localparam logic [RW-1:0] DLY_LOAD = RW'((RST_DLY > 0) ? RST_DLY - 1 : 0);

    typedef enum logic [1:0] {IDLE, UP, DOWN, RST} state_t;

    // Without an overlap window a finished comparison returns straight to IDLE
    localparam state_t AFTER_CMP = (RST_DLY == 0) ? IDLE : RST;

    state_t           state, state_nx;
    logic [ERR_W-1:0] cnt, cnt_nx, cnt_inc, err_nx;
    logic [RW-1:0]    dly, dly_nx;
    logic             done, sign_nx, slip_nx, slip_seen, bad;
    logic [GW-1:0]    good_cnt;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + ERR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dly   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            dly   <= dly_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dly_nx   = dly;
        done     = 1'b0;
        err_nx   = phase_err;
        sign_nx  = err_sign;
        slip_nx  = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ref_edge && fb_edge) begin
                        done   = 1'b1;
                        err_nx = '0;
                        sign_nx = 1'b0;
                        state_nx = AFTER_CMP;
                        dly_nx = DLY_LOAD;
                    end else if (ref_edge) begin
                        state_nx = UP;
                        cnt_nx = ERR_W'(1);
                    end else if (fb_edge) begin
                        state_nx = DOWN;
                        cnt_nx = ERR_W'(1);
                    end
                end
                UP: begin
                    // A repeated leading edge is a slip, with or without completion
                    slip_nx = ref_edge;
                    if (fb_edge) begin
                        done   = 1'b1;
                        err_nx = cnt;
                        sign_nx = 1'b0;
                        state_nx = AFTER_CMP;
                        dly_nx = DLY_LOAD;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                DOWN: begin
                    slip_nx = fb_edge;
                    if (ref_edge) begin
                        done   = 1'b1;
                        err_nx = cnt;
                        sign_nx = 1'b1;
                        state_nx = AFTER_CMP;
                        dly_nx = DLY_LOAD;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                RST: begin
                    // Edges are ignored while both pulses overlap
                    if (dly == '0) state_nx = IDLE;
                    else dly_nx = dly - RW'(1);
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        up_pulse   = (state == UP) || (state == RST);
        down_pulse = (state == DOWN) || (state == RST);
    end

    // A comparison is bad if it slipped, follows an earlier slip, or exceeds tolerance
    assign bad = slip_nx || (done && (slip_seen || err_nx > ERR_W'(LOCK_TOL)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_err <= '0;
            err_sign  <= 1'b0;
            err_valid <= 1'b0;
            slip      <= 1'b0;
            slip_seen <= 1'b0;
            good_cnt  <= '0;
            locked    <= 1'b0;
        end else if (!enable) begin
            err_valid <= 1'b0;
            slip      <= 1'b0;
            slip_seen <= 1'b0;
            good_cnt  <= '0;
            locked    <= 1'b0;
        end else begin
            phase_err <= err_nx;
            err_sign  <= sign_nx;
            err_valid <= done;
            slip      <= slip_nx;
            if (bad) begin
                good_cnt  <= '0;
                locked    <= 1'b0;
                // A slip that also completes a comparison is consumed by that comparison
                slip_seen <= slip_nx && !done;
            end else begin
                // locked follows good_cnt by one cycle
                locked <= (good_cnt == GW'(LOCK_CNT));
                if (done) begin
                    good_cnt  <= (good_cnt == GW'(LOCK_CNT)) ? good_cnt : good_cnt + GW'(1);
                    slip_seen <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_serdesphy_ana_pll_pfd.sv
// tb_serdesphy_ana_pll_pfd: randomized self-checking bench against a timestamp-based PFD model
module tb_serdesphy_ana_pll_pfd;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       ref_edge = 1'b0;
    logic       fb_edge = 1'b0;
    logic [1:0] up, dn, sg, ev, sl, lk;
    logic [7:0] pe [2];

    int n_chk = 0;
    int n_bad = 0;
    int t = 0;

    // Model per instance: 0 has a one-cycle overlap window, 1 has none
    int m_lead [2];
    int m_lt [2];
    int m_blank [2];
    int m_err [2];
    int m_sign [2];
    int m_ev [2];
    int m_slp [2];
    int m_run [2];
    int m_lk [2];
    int m_seen [2];

    always #5 clk = ~clk;

    serdesphy_ana_pll_pfd #(.RST_DLY(1)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .ref_edge(ref_edge), .fb_edge(fb_edge),
        .up_pulse(up[0]), .down_pulse(dn[0]), .phase_err(pe[0]), .err_sign(sg[0]),
        .err_valid(ev[0]), .slip(sl[0]), .locked(lk[0])
    );

    serdesphy_ana_pll_pfd #(.RST_DLY(0)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .ref_edge(ref_edge), .fb_edge(fb_edge),
        .up_pulse(up[1]), .down_pulse(dn[1]), .phase_err(pe[1]), .err_sign(sg[1]),
        .err_valid(ev[1]), .slip(sl[1]), .locked(lk[1])
    );

    task automatic chk(input string tag, input int k, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s[%0d] t=%0d got=%0d exp=%0d", tag, k, t, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lead[k] = 0; m_lt[k] = 0; m_blank[k] = 0; m_err[k] = 0; m_sign[k] = 0;
            m_ev[k] = 0; m_slp[k] = 0; m_run[k] = 0; m_lk[k] = 0; m_seen[k] = 0;
        end
    endtask

    // Leading edge time is remembered; the error is simply the elapsed time, capped
    task automatic model(input int k, input bit r, input bit f, input bit e);
        bit done, lag, bad;
        done = 0;
        m_ev[k] = 0;
        m_slp[k] = 0;
        if (!e) begin
            m_lead[k] = 0; m_blank[k] = 0; m_run[k] = 0; m_lk[k] = 0; m_seen[k] = 0;
            return;
        end
        if (m_blank[k] > 0) begin
            m_blank[k]--;
        end else if (m_lead[k] == 0) begin
            if (r && f) begin
                done = 1; m_err[k] = 0; m_sign[k] = 0;
            end else if (r || f) begin
                m_lead[k] = r ? 1 : 2;
                m_lt[k] = t;
            end
        end else begin
            lag = (m_lead[k] == 1) ? f : r;
            m_slp[k] = (m_lead[k] == 1) ? r : f;
            if (lag) begin
                done = 1;
                m_err[k] = (t - m_lt[k] > 255) ? 255 : t - m_lt[k];
                m_sign[k] = (m_lead[k] == 2);
                m_lead[k] = 0;
            end
        end
        if (done) begin
            m_ev[k] = 1;
            m_blank[k] = (k == 0) ? 1 : 0;
        end
        bad = m_slp[k] || (done && (m_seen[k] != 0 || m_err[k] > 2));
        if (bad) begin
            m_run[k] = 0;
            m_lk[k] = 0;
            m_seen[k] = m_slp[k] && !done;
        end else begin
            m_lk[k] = (m_run[k] >= 16);
            if (done) m_run[k]++;
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            chk("up", k, up[k], (m_lead[k] == 1 || m_blank[k] > 0) ? 1 : 0);
            chk("down", k, dn[k], (m_lead[k] == 2 || m_blank[k] > 0) ? 1 : 0);
            chk("phase_err", k, pe[k], m_err[k]);
            chk("err_sign", k, sg[k], m_sign[k]);
            chk("err_valid", k, ev[k], m_ev[k]);
            chk("slip", k, sl[k], m_slp[k]);
            chk("locked", k, lk[k], m_lk[k]);
        end
    endtask

    task automatic step(input bit r, input bit f, input bit e);
        ref_edge = r;
        fb_edge = f;
        enable = e;
        @(posedge clk);
        t++;
        for (int k = 0; k < 2; k++) model(k, r, f, e);
        #1;
        compare();
    endtask

    // One comparison: lead=1 means ref leads; d cycles apart, then gap idle cycles
    task automatic pair(input int d, input bit lead, input int gap);
        if (d == 0) begin
            step(1, 1, 1);
        end else begin
            step(lead, !lead, 1);
            repeat (d - 1) step(0, 0, 1);
            step(!lead, lead, 1);
        end
        repeat (gap) step(0, 0, 1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        rst = 1'b0;
        repeat (3) step(0, 0, 1);
        // ref leads by 3, fb leads by 2, simultaneous
        pair(3, 1, 3);
        pair(2, 0, 3);
        pair(0, 1, 3);
        // slip: ref, ref 5 later, fb 3 later, then an edge inside the overlap window
        step(1, 0, 1);
        repeat (4) step(0, 0, 1);
        step(1, 0, 1);
        repeat (2) step(0, 0, 1);
        step(0, 1, 1);
        step(1, 0, 1);
        repeat (3) step(0, 0, 1);
        // lock, then a bad comparison, then lock again and disable
        repeat (16) pair($urandom_range(0, 2), 1'($urandom), 2);
        step(0, 0, 1);
        pair(5, 1, 2);
        repeat (17) pair($urandom_range(0, 2), 1'($urandom), 1);
        repeat (2) step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 1);
        // saturation of the error counter
        pair(300, 0, 3);
        // asynchronous reset during an active UP
        step(1, 0, 1);
        step(0, 0, 1);
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        @(posedge clk);
        #1;
        compare();
        rst = 1'b0;
        repeat (3) step(0, 0, 1);
        // structured random comparisons
        repeat (300) begin
            if ($urandom % 40 == 0) step(0, 0, 0);
            pair(($urandom % 8 == 0) ? $urandom_range(3, 9) : $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3));
        end
        // unstructured random edges
        repeat (2000) step($urandom % 6 == 0, $urandom % 6 == 0, $urandom % 100 != 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/serdesphy_ana_pll_pfd.md
Name: serdesphy_ana_pll_pfd

Overview:
- Behavioural phase-frequency detector for the PLL. It is the source end of the UP/DOWN interface that drives the PLL charge pump.
- Compares single-cycle reference-edge and feedback-edge strobes, already synchronised into the clk domain.
- Generates tri-state UP/DOWN pulses, with a both-high reset window to model dead-zone avoidance.
- Also reports measured phase error per comparison, flags cycle slips, and provides a lock indicator for PLL status.

Parameters:
- RST_DLY, 1: cycles both up_pulse and down_pulse stay high after a comparison completes. 0 means no overlap window.
- ERR_W, 8: width of the phase error counter.
- LOCK_TOL, 2: maximum phase_err, in cycles, counted as a good comparison.
- LOCK_CNT, 16: consecutive good comparisons required to assert locked.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  detector enable
- ref_edge  in  1  one-cycle strobe, reference clock edge
- fb_edge  in  1  one-cycle strobe, divided feedback clock edge
- up_pulse  out  1  UP to charge pump (reference leads)
- down_pulse  out  1  DOWN to charge pump (feedback leads)
- phase_err  out  ERR_W  magnitude of last comparison, in clk cycles
- err_sign  out  1  0 = ref led, 1 = fb led
- err_valid  out  1  one-cycle strobe, new phase_err/err_sign
- slip  out  1  one-cycle strobe, second leading edge before lagging edge
- locked  out  1  lock indicator

Behaviour:
- Reset: rst asserted clears all outputs, FSM state, error counter and lock counter to 0, asynchronously.
- Timing convention: all outputs are registered. An input sampled at clk edge k affects outputs after edge k.
- FSM states are IDLE, UP, DOWN, RST. up_pulse = (UP or RST). down_pulse = (DOWN or RST).
- IDLE:
  - ref_edge & fb_edge together: phase_err=0, err_sign=0, err_valid=1, go to RST (or stay IDLE if RST_DLY=0).
  - ref_edge only: go to UP, cnt=1.
  - fb_edge only: go to DOWN, cnt=1.
- UP:
  - Each cycle without fb_edge: cnt++, saturating at 2^ERR_W-1.
  - fb_edge: phase_err=cnt, err_sign=0, err_valid=1, go to RST (IDLE if RST_DLY=0).
  - ref_edge without fb_edge: slip=1, stay in UP, cnt continues.
  - ref_edge & fb_edge together: complete the comparison as for fb_edge and also assert slip=1.
- DOWN: mirror of UP, with roles of ref_edge/fb_edge swapped and err_sign=1.
- RST:
  - Held for exactly RST_DLY cycles, then returns to IDLE.
  - Edges arriving during RST are ignored, as in a real PFD: no slip, no restart.
- Net result: phase_err equals the number of cycles between the leading and lagging sampling edges, e.g. ref at edge N and fb at edge M gives M-N.
- err_valid and slip are high for one cycle only. phase_err and err_sign hold their value until the next comparison.
- Lock counter (good_cnt), evaluated on each err_valid:
  - If phase_err <= LOCK_TOL and no slip occurred since the previous err_valid: good_cnt++, saturating at LOCK_CNT.
  - Otherwise: good_cnt=0 and locked=0.
  - locked=1 in the cycle after good_cnt reaches LOCK_CNT, and stays 1 until a bad comparison or a slip.
  - A slip clears good_cnt and locked immediately.
- enable=0 (synchronous):
  - FSM forced to IDLE; up/down/err_valid/slip forced to 0.
  - good_cnt=0, locked=0.
  - phase_err and err_sign hold.
  - Edges are ignored while enable is low. Operation resumes from IDLE on the first edge after enable returns high.
- Reset mid-pulse: up/down drop immediately. No err_valid is generated for the aborted comparison.

Test Plan:
1. Reset: assert rst during an active UP -> up_pulse/down_pulse/locked/phase_err become 0 immediately; outputs stay 0 with no edges applied after release.
2. ref at edge 10, fb at edge 13, RST_DLY=1 -> up_pulse high after edges 10-12; up and down both high for the one cycle after edge 13; err_valid=1 with phase_err=3, err_sign=0 in that cycle; IDLE after edge 14.
3. Feedback leads: fb at edge 20, ref at edge 22 -> down_pulse high for 2 cycles, then 1 overlap cycle; phase_err=2, err_sign=1.
4. Simultaneous: ref and fb both at edge 30 -> err_valid with phase_err=0; both outputs high for RST_DLY cycles; with RST_DLY=0 neither output ever asserts.
5. Slip: ref at edges 40 and 45, fb at 48 -> slip strobe after edge 45; phase_err=8; locked cleared; an edge arriving during RST is ignored.
6. Lock: 16 comparisons with phase_err ≤ 2 -> locked rises the cycle after the 16th err_valid; a 17th comparison with phase_err=5 -> locked falls; enable=0 also clears locked.
